// File: rtl/mdu_if.sv
// mdu_if: E-stage bundle between the pipeline and the multiply/divide unit.
//   master (pipeline side) drives : in_valid, mult, multu, div, divu,
//                                   mthi, mtlo, mfhi, mflo, A, B
//   master observes               : start, busy, HI, LO, rd_data
//   slave  (mdu side) sees the mirror image of the above.
interface mdu_if;
  logic        in_valid;
  logic        mult;
  logic        multu;
  logic        div;
  logic        divu;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  modport master (
    output in_valid, mult, multu, div, divu, mthi, mtlo, mfhi, mflo, A, B,
    input  start, busy, HI, LO, rd_data
  );

  modport slave (
    input  in_valid, mult, multu, div, divu, mthi, mtlo, mfhi, mflo, A, B,
    output start, busy, HI, LO, rd_data
  );
endinterface

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the MIPS E stage.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low (0 = reset)
//   bus   : mdu_if.slave
//     in_valid + one-hot decode lines (mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
//     A/B    forwarded rs/rt operands
//     start  combinational, a mult/div is accepted at this edge
//     busy   registered, an operation is in flight
//     HI/LO  architectural registers
//     rd_data combinational mfhi ? HI : LO
// The result is computed in the accept cycle and parked in pend_hi/pend_lo;
// a down-counter models the architectural latency and commits the pending
// result into HI/LO on the edge where it reaches zero.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  function automatic hilo_t mul_signed(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    logic signed [2*DATA_W-1:0] p;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    p  = ax * bx;
    return hilo_t'(p);
  endfunction

  function automatic hilo_t mul_unsigned(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return hilo_t'(p);
  endfunction

  // Signed divide on magnitudes so 0x80000000 / -1 needs no special case:
  // the magnitude quotient 0x80000000 keeps its bit pattern after the sign fix.
  function automatic hilo_t div_signed(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b,
                                       input hilo_t             cur);
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    hilo_t             res;
    if (b == '0) begin
      res = cur;
    end else begin
      mag_a  = a[DATA_W-1] ? -a : a;
      mag_b  = b[DATA_W-1] ? -b : b;
      q      = mag_a / mag_b;
      r      = mag_a % mag_b;
      res.lo = (a[DATA_W-1] ^ b[DATA_W-1]) ? -q : q;
      res.hi = a[DATA_W-1] ? -r : r;
    end
    return res;
  endfunction

  function automatic hilo_t div_unsigned(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input hilo_t             cur);
    hilo_t res;
    if (b == '0) begin
      res = cur;
    end else begin
      res.lo = a / b;
      res.hi = a % b;
    end
    return res;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic              busy_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic [DATA_W-1:0] pend_hi;
  logic [DATA_W-1:0] pend_lo;

  logic              is_arith;
  logic              is_mul;
  logic              start_c;
  hilo_t             res_c;
  hilo_t             cur_c;
  logic              rd_lo_unused;

  assign is_arith = bus.mult | bus.multu | bus.div | bus.divu;
  assign is_mul   = bus.mult | bus.multu;
  assign start_c  = bus.in_valid & is_arith & ~busy_r;
  assign cur_c    = '{hi: hi_r, lo: lo_r};

  // Decode priority: mult > multu > div > divu.
  always_comb begin
    res_c = cur_c;
    if (bus.mult)       res_c = mul_signed(bus.A, bus.B);
    else if (bus.multu) res_c = mul_unsigned(bus.A, bus.B);
    else if (bus.div)   res_c = div_signed(bus.A, bus.B, cur_c);
    else if (bus.divu)  res_c = div_unsigned(bus.A, bus.B, cur_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      busy_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (busy_r) begin
      // In flight: every decode line is ignored until the commit edge.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy_r <= 1'b0;
        hi_r   <= pend_hi;
        lo_r   <= pend_lo;
      end
    end else if (start_c) begin
      pend_hi <= res_c.hi;
      pend_lo <= res_c.lo;
      cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      busy_r  <= 1'b1;
    end else if (bus.in_valid) begin
      if (bus.mthi)      hi_r <= bus.A;
      else if (bus.mtlo) lo_r <= bus.A;
    end
  end

  // mflo is the default read path, so the line itself carries no extra choice.
  assign rd_lo_unused = bus.mflo;

  assign bus.start   = start_c;
  assign bus.busy    = busy_r;
  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;
  assign bus.rd_data = bus.mfhi ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with an expected-result queue.
module tb_mdu;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb_q[$];

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    bus.in_valid = 1'b0;
    bus.mult = 1'b0; bus.multu = 1'b0; bus.div = 1'b0; bus.divu = 1'b0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mfhi = 1'b0; bus.mflo = 1'b0;
    bus.A = '0; bus.B = '0;
  endtask

  task automatic set_op(input int op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    case (op)
      OP_MULT:  bus.mult  = 1'b1;
      OP_MULTU: bus.multu = 1'b1;
      OP_DIV:   bus.div   = 1'b1;
      OP_DIVU:  bus.divu  = 1'b1;
      OP_MTHI:  bus.mthi  = 1'b1;
      default:  bus.mtlo  = 1'b1;
    endcase
  endtask

  // Presents one op for a single edge; returns at the negedge after that edge.
  task automatic drive_op(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic exp_start);
    @(negedge clk);
    set_op(op, a, b);
    #1;
    check({tag, "_start"}, {31'b0, bus.start}, {31'b0, exp_start});
    @(negedge clk);
    clear_bus();
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
    sb_q.push_back({hi, lo});
  endtask

  // Counts busy negedges (bounded), then pops the oldest expectation.
  task automatic wait_done(input string tag, input int exp_cycles, input int n0);
    int n;
    logic [63:0] e;
    n = n0;
    while (bus.busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_HI"}, bus.HI, e[63:32]);
      check({tag, "_LO"}, bus.LO, e[31:0]);
    end else begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    longint      sp;
    logic [63:0] up;

    clear_bus();
    reset = 1'b0;
    #2;
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_HI", bus.HI, 32'h0);
    check("rst_LO", bus.LO, 32'h0);
    check("rst_start", {31'b0, bus.start}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a divide
    drive_op("pre_mthi", OP_MTHI, 32'hAAAA_AAAA, 32'h0, 1'b0);
    drive_op("pre_mtlo", OP_MTLO, 32'h5555_5555, 32'h0, 1'b0);
    check("pre_HI", bus.HI, 32'hAAAA_AAAA);
    check("pre_LO", bus.LO, 32'h5555_5555);
    drive_op("abort_divu", OP_DIVU, 32'd100, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    check("abort_busy_before", {31'b0, bus.busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_HI", bus.HI, 32'h0);
    check("abort_LO", bus.LO, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_abort_busy", {31'b0, bus.busy}, 32'h0);
    check("post_abort_HI", bus.HI, 32'h0);
    check("post_abort_LO", bus.LO, 32'h0);

    // Multiplies
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    drive_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    check("mult_start_drop", {31'b0, bus.start}, 32'h0);
    wait_done("mult", 5, 0);
    push_exp(32'h0000_0002, 32'hFFFF_FFFA);
    drive_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_done("multu", 5, 0);

    // Divides
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div", 10, 0);
    push_exp(32'd1, 32'd3);
    drive_op("divu", OP_DIVU, 32'd7, 32'd2, 1'b1);
    wait_done("divu", 10, 0);
    push_exp(32'h0, 32'h8000_0000);
    drive_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf", 10, 0);

    // Divide by zero keeps HI/LO
    drive_op("dz_mthi", OP_MTHI, 32'h0000_1234, 32'h0, 1'b0);
    drive_op("dz_mtlo", OP_MTLO, 32'h0000_5678, 32'h0, 1'b0);
    push_exp(32'h0000_1234, 32'h0000_5678);
    drive_op("divu_z", OP_DIVU, 32'd99, 32'd0, 1'b1);
    wait_done("divu_z", 10, 0);

    // Moves and reads
    drive_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus.in_valid = 1'b1; bus.mfhi = 1'b1;
    #1 check("mfhi_rd", bus.rd_data, 32'hDEAD_BEEF);
    clear_bus();
    drive_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0);
    bus.in_valid = 1'b1; bus.mflo = 1'b1;
    #1 check("mflo_rd", bus.rd_data, 32'hCAFE_F00D);
    check("mflo_HI_kept", bus.HI, 32'hDEAD_BEEF);
    check("mflo_busy", {31'b0, bus.busy}, 32'h0);
    clear_bus();

    // Random multiplies and unsigned divides against an integer model
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      sp = longint'(signed'(ra)) * longint'(signed'(rb));
      push_exp(sp[63:32], sp[31:0]);
      drive_op("rnd_mult", OP_MULT, ra, rb, 1'b1);
      wait_done("rnd_mult", 5, 0);
      up = {32'h0, ra} * {32'h0, rb};
      push_exp(up[63:32], up[31:0]);
      drive_op("rnd_multu", OP_MULTU, ra, rb, 1'b1);
      wait_done("rnd_multu", 5, 0);
      rb = $urandom_range(1, 5000);
      push_exp(ra % rb, ra / rb);
      drive_op("rnd_divu", OP_DIVU, ra, rb, 1'b1);
      wait_done("rnd_divu", 10, 0);
    end

    // Operations presented while busy are ignored
    drive_op("pv_mtlo0", OP_MTLO, 32'h0BAD_F00D, 32'h0, 1'b0);
    sp = longint'(signed'(32'h1234_5678)) * longint'(signed'(32'h9ABC_DEF0));
    push_exp(sp[63:32], sp[31:0]);
    drive_op("pv_mult", OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("protocol violation flagged: mtlo issued while mdu busy");
    set_op(OP_MTLO, 32'h1, 32'h0);
    @(negedge clk);
    clear_bus();
    check("pv_LO_kept", bus.LO, 32'h0BAD_F00D);
    set_op(OP_MULT, 32'h7, 32'h7);
    #1 check("pv_start_blocked", {31'b0, bus.start}, 32'h0);
    @(negedge clk);
    clear_bus();
    wait_done("pv_mult", 5, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the E stage of the five-stage MIPS pipeline.
- Consumes the one-hot decode lines mult, multu, div, divu, mfhi, mflo, mthi and mtlo, together with the forwarded rs/rt operands.
- Holds the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- The hazard unit uses start/busy to stall D-stage multiply/divide instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start edge.
- DIV_CYCLES, 10, busy cycles after a div/divu start edge.
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  E-stage instruction valid (0 on bubble/flush).
- mult  input  1  decoded signed multiply.
- multu  input  1  decoded unsigned multiply.
- div  input  1  decoded signed divide.
- divu  input  1  decoded unsigned divide.
- mthi  input  1  decoded move-to-HI.
- mtlo  input  1  decoded move-to-LO.
- mfhi  input  1  decoded move-from-HI.
- mflo  input  1  decoded move-from-LO.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- start  output  1  combinational: in_valid & (mult|multu|div|divu) & ~busy.
- busy  output  1  registered: counter != 0.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- rd_data  output  32  combinational: mfhi ? HI : LO (valid whenever mfhi|mflo and ~busy).

Behaviour:
- Reset (reset=0, async): counter=0, busy=0, HI=0, LO=0, pending result regs=0. Any in-flight operation is discarded. The first edge after deassertion behaves as idle.
- Idle (busy=0), start=1 at a rising edge:
  - Compute the result combinationally from A/B and latch it into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - HI/LO are unchanged at this edge.
- Busy: counter decrements by 1 per edge. On the edge where counter goes 1->0, HI<=pend_hi and LO<=pend_lo. busy falls in the same cycle the new HI/LO become visible.
  - Net: a mult started at edge t0 has busy=1 for the 5 cycles after t0; HI/LO are updated at edge t0+5.
- Multiply results:
  - mult: {HI,LO} = signed(A)*signed(B), full 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
- Divide results:
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned LO=quotient, HI=remainder.
  - Divide by zero (B=0): the full DIV_CYCLES busy period is still taken, but HI/LO keep their prior values (pending is loaded from the current HI/LO).
- mthi/mtlo (in_valid=1, busy=0): HI<=A or LO<=A at that edge, no busy.
- mfhi/mflo: purely combinational read; no state change.
- Any operation presented while busy=1 is ignored; state is unaffected. The hazard unit must stall it in D instead. The bench flags this as a protocol violation.
- in_valid=0: all decode lines are ignored.
- More than one decode line high is illegal. For determinism, priority is mult > multu > div > divu > mthi > mtlo.
- No pipelining: at most one operation in flight.

Test Plan:
1. Reset low mid-div (counter=6) -> HI=LO=0, busy=0 immediately (async). After release, HI/LO are not updated by the aborted op.
2. mult A=0xFFFFFFFE(-2), B=3 -> start=1 for one cycle, busy=1 for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu A=7, B=2 -> LO=3, HI=1.
4. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Then divu with B=0 after mthi 0x1234/mtlo 0x5678 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
5. mthi A=0xDEADBEEF, next cycle mfhi -> rd_data=0xDEADBEEF. mtlo then mflo -> rd_data equals the written value.
6. Issue mult, then drive mtlo A=0x1 at the 3rd busy cycle -> LO is not written by mtlo. Final LO equals the product's LO; the bench flags the violation.
